// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_tdm_tx                                                                 |
// | Parametrised I2S / left- / right-justified / TDM serial audio transmitter. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module i2s_tdm_tx #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int SLOT     = 32,
  parameter int SCK_HALF = 2,
  parameter int MCK_DIV  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      mute,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      mck,
  output logic                      sck,
  output logic                      lr,
  output logic                      d,
  output logic                      frame,
  output logic                      underrun
);

  localparam int c_MW = $clog2(MCK_DIV);
  localparam int c_HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int c_KW = $clog2(SLOT);
  localparam int c_CW = $clog2(CHANNELS);

  logic [c_MW-1:0]           r_mck_cnt;
  logic [c_HW-1:0]           r_sck_cnt;
  logic [c_KW-1:0]           r_k;
  logic [c_CW-1:0]           r_c;
  logic [1:0]                r_mode;
  logic [CHANNELS*WIDTH-1:0] r_hold;
  logic                      r_hold_full;
  logic [CHANNELS*WIDTH-1:0] r_shift;
  logic                      r_mck, r_sck, r_lr, r_d, r_frame, r_underrun;

  logic [c_MW-1:0]           w_mck_next;
  logic                      w_sck_wrap, w_fall, w_pos0, w_start, w_accept;
  logic [1:0]                w_mode_new, w_mode;
  logic [CHANNELS*WIDTH-1:0] w_load, w_frame;
  logic [WIDTH-1:0]          w_sample, w_shifted;
  logic [5:0]                w_k6, w_idx;
  logic                      w_en, w_bit, w_lr;

  assign w_mck_next = (r_mck_cnt == c_MW'(MCK_DIV-1)) ? '0 : r_mck_cnt + 1'b1;
  assign w_sck_wrap = (r_sck_cnt == c_HW'(SCK_HALF-1));
  assign w_fall     = w_sck_wrap & r_sck;
  assign w_pos0     = (r_k == '0) && (r_c == '0);
  assign w_start    = w_fall & w_pos0;
  assign w_accept   = in_valid & ~r_hold_full;
  assign w_mode_new = (mode == 2'd3) ? 2'd0 : mode;

  // The bit emitted on the frame-start clock already comes from the frame and mode being loaded.
  assign w_mode  = w_start ? w_mode_new : r_mode;
  assign w_load  = mute ? '0 : (r_hold_full ? r_hold : r_shift);
  assign w_frame = w_start ? w_load : r_shift;

  always_comb begin
    w_sample = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_c == c_CW'(i)) w_sample = w_frame[(CHANNELS-1-i)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_k6  = 6'(r_k);
    w_idx = '0;
    w_en  = 1'b0;
    case (w_mode)
      2'd1: begin
        w_en  = (w_k6 < 6'(WIDTH));
        w_idx = 6'(WIDTH-1) - w_k6;
      end
      2'd2: begin
        w_en  = (w_k6 >= 6'(SLOT-WIDTH));
        w_idx = 6'(SLOT-1) - w_k6;
      end
      default: begin
        w_en  = (w_k6 != 6'd0) && (w_k6 <= 6'(WIDTH));
        w_idx = 6'(WIDTH) - w_k6;
      end
    endcase
    w_shifted = w_sample >> w_idx;
    w_bit     = w_en & w_shifted[0];
    if (CHANNELS == 2) w_lr = (w_mode == 2'd0) ? (r_c != '0) : (r_c == '0);
    else               w_lr = w_pos0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mck_cnt   <= '0;
      r_sck_cnt   <= '0;
      r_k         <= '0;
      r_c         <= '0;
      r_mode      <= 2'd0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_mck       <= 1'b0;
      r_sck       <= 1'b0;
      r_lr        <= 1'b0;
      r_d         <= 1'b0;
      r_frame     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_mck_cnt  <= w_mck_next;
      r_mck      <= (w_mck_next >= c_MW'(MCK_DIV/2));
      r_sck_cnt  <= w_sck_wrap ? '0 : r_sck_cnt + 1'b1;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      if (w_sck_wrap) r_sck <= ~r_sck;
      // Accept never coincides with a full-hold frame start, so the two hold updates cannot collide.
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end
      if (w_fall) begin
        r_d  <= w_bit;
        r_lr <= w_lr;
        if (r_k == c_KW'(SLOT-1)) begin
          r_k <= '0;
          r_c <= (r_c == c_CW'(CHANNELS-1)) ? '0 : r_c + 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
        if (w_start) begin
          r_frame    <= 1'b1;
          r_mode     <= w_mode_new;
          r_shift    <= w_load;
          r_underrun <= ~r_hold_full;
          if (r_hold_full) r_hold_full <= 1'b0;
        end
      end
    end
  end

  assign in_ready = ~r_hold_full;
  assign mck      = r_mck;
  assign sck      = r_sck;
  assign lr       = r_lr;
  assign d        = r_d;
  assign frame    = r_frame;
  assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
`default_nettype none
// Bench for i2s_tdm_tx: a 2-channel default instance and a 4-channel 24-bit TDM instance,
// checked bit by bit at each falling SCK edge against a queue of expected frame bits.
module tb_i2s_tdm_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic [1:0]  mode_a, mode_b;
  logic        mute_a, mute_b;
  logic [31:0] data_a;
  logic [95:0] data_b;
  logic        valid_a, valid_b;
  logic        ready_a, mck_a, sck_a, lr_a, d_a, frame_a, und_a;
  logic        ready_b, mck_b, sck_b, lr_b, d_b, frame_b, und_b;

  i2s_tdm_tx dut_a (
    .clock(clock), .reset(rst_a), .mode(mode_a), .mute(mute_a),
    .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
    .mck(mck_a), .sck(sck_a), .lr(lr_a), .d(d_a), .frame(frame_a), .underrun(und_a)
  );

  i2s_tdm_tx #(.CHANNELS(4), .WIDTH(24), .SLOT(32), .SCK_HALF(2), .MCK_DIV(4)) dut_b (
    .clock(clock), .reset(rst_b), .mode(mode_b), .mute(mute_b),
    .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
    .mck(mck_b), .sck(sck_b), .lr(lr_b), .d(d_b), .frame(frame_b), .underrun(und_b)
  );

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  q[$];
  logic [23:0] smp [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_d(input int md, input int c, input int k, input int w, input int s);
    logic [23:0] v;
    v = smp[c];
    case (md)
      1:       return (k < w) ? v[w-1-k] : 1'b0;
      2:       return (k >= s - w) ? v[s-1-k] : 1'b0;
      default: return (k >= 1 && k <= w) ? v[w-k] : 1'b0;
    endcase
  endfunction

  function automatic logic exp_lr(input int md, input int chans, input int c, input int k);
    if (chans == 2) return (md == 1 || md == 2) ? (c == 0) : (c == 1);
    return (c == 0 && k == 0);
  endfunction

  // Expected tuple per bit position: {frame, underrun, lr, d}.
  task automatic push_frame(input int chans, input int w, input int s, input int md, input logic und);
    for (int c = 0; c < chans; c++) begin
      for (int k = 0; k < s; k++) begin
        q.push_back({(c == 0 && k == 0), (und && c == 0 && k == 0), exp_lr(md, chans, c, k),
                     exp_d(md, c, k, w, s)});
      end
    end
  endtask

  task automatic drain(input logic sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int   waited;
      logic got, prev, cur;
      logic [3:0] obs, exp;
      waited = 0;
      got    = 1'b0;
      prev   = sel ? sck_b : sck_a;
      while (!got && waited < 64) begin
        @(negedge clock);
        waited++;
        cur = sel ? sck_b : sck_a;
        if (prev && !cur) got = 1'b1;
        prev = cur;
      end
      if (!got || q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s bit %0d: no falling sck edge or empty scoreboard (got=%0d queued=%0d)",
               tag, i, got, q.size());
      end else begin
        exp = q.pop_front();
        obs = sel ? {frame_b, und_b, lr_b, d_b} : {frame_a, und_a, lr_a, d_a};
        check($sformatf("%s bit %0d {frame,underrun,lr,d}", tag, i), 32'(obs), 32'(exp));
      end
    end
  endtask

  task automatic write_a(input logic [31:0] v);
    data_a  = v;
    valid_a = 1'b1;
    @(negedge clock);
    valid_a = 1'b0;
  endtask

  task automatic write_b(input logic [95:0] v);
    data_b  = v;
    valid_b = 1'b1;
    @(negedge clock);
    valid_b = 1'b0;
  endtask

  task automatic set_smp(input logic [23:0] s0, input logic [23:0] s1,
                         input logic [23:0] s2, input logic [23:0] s3);
    smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
    for (int i = 4; i < 8; i++) smp[i] = '0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    mode_a = 2'd0; mode_b = 2'd1;
    mute_a = 1'b0; mute_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    set_smp(0, 0, 0, 0);
    repeat (3) @(negedge clock);

    check("reset outputs A", 32'({mck_a, sck_a, lr_a, d_a, frame_a, und_a}), 32'd0);
    check("reset in_ready A", 32'(ready_a), 32'd1);
    check("reset outputs B", 32'({mck_b, sck_b, lr_b, d_b, frame_b, und_b}), 32'd0);

    // Release A and check the first clock divider cycles.
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check($sformatf("mck/sck after %0d clocks", i), 32'({mck_a, sck_a}),
            32'({(i % 4) >= 2, ((i / 2) % 2) == 1}));
    end

    // Frame 1: no sample yet -> underrun, silent.
    push_frame(2, 16, 32, 0, 1'b1);
    drain(0, 1, "f1 underrun");
    write_a({16'hA5C3, 16'h8001});
    check("in_ready after write", 32'(ready_a), 32'd0);
    drain(0, 63, "f1 underrun");

    // Frame 2: I2S data; mode change mid-frame must not affect it.
    set_smp(24'hA5C3, 24'h8001, 0, 0);
    push_frame(2, 16, 32, 0, 1'b0);
    drain(0, 1, "f2 i2s");
    check("in_ready after frame start", 32'(ready_a), 32'd1);
    mode_a = 2'd1;
    write_a({16'hA5C3, 16'h8001});
    drain(0, 63, "f2 i2s");

    // Frame 3: left-justified.
    push_frame(2, 16, 32, 1, 1'b0);
    drain(0, 1, "f3 ljust");
    mode_a = 2'd2;
    write_a({16'hA5C3, 16'h8001});
    drain(0, 63, "f3 ljust");

    // Frame 4: right-justified, no write follows.
    push_frame(2, 16, 32, 2, 1'b0);
    drain(0, 64, "f4 rjust");

    // Frame 5: underrun repeats frame 4 bit-exact.
    push_frame(2, 16, 32, 2, 1'b1);
    drain(0, 1, "f5 repeat");
    write_a({16'h1234, 16'hFEDC});
    mute_a = 1'b1;
    drain(0, 63, "f5 repeat");

    // Frame 6: muted load consumes the hold and sends zeros.
    set_smp(0, 0, 0, 0);
    push_frame(2, 16, 32, 2, 1'b0);
    drain(0, 1, "f6 mute");
    mute_a = 1'b0;
    drain(0, 63, "f6 mute");

    // Frame 7: hold was consumed by the muted load -> underrun; reset at p=40 with data pending.
    push_frame(2, 16, 32, 2, 1'b1);
    drain(0, 1, "f7 after mute");
    write_a({16'h5555, 16'hAAAA});
    drain(0, 40, "f7 after mute");
    rst_a = 1'b1;
    #1;
    check("async reset outputs", 32'({mck_a, sck_a, lr_a, d_a, frame_a, und_a}), 32'd0);
    check("async reset in_ready", 32'(ready_a), 32'd1);
    q.delete();
    repeat (2) @(negedge clock);
    mode_a = 2'd0;
    rst_a  = 1'b0;
    push_frame(2, 16, 32, 0, 1'b1);
    drain(0, 64, "post reset");

    // TDM instance: four 24-bit channels, left-justified, one write per frame.
    set_smp(24'h800001, 24'h7FFFFF, 24'h000000, 24'hFFFFFF);
    rst_b = 1'b0;
    write_b({24'h800001, 24'h7FFFFF, 24'h000000, 24'hFFFFFF});
    check("tdm in_ready after write", 32'(ready_b), 32'd0);
    push_frame(4, 24, 32, 1, 1'b0);
    drain(1, 1, "tdm f1");
    write_b({24'h800001, 24'h7FFFFF, 24'h000000, 24'hFFFFFF});
    drain(1, 127, "tdm f1");
    push_frame(4, 24, 32, 1, 1'b0);
    drain(1, 128, "tdm f2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
